// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU memory-side blocks.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_INSTR,
    BUS_DATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_INSTR,
    GRANT_DATA
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // A word access must sit on a 4-byte boundary.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mips_cpu_wait_timer.sv
// Saturating stall counter with synchronous clear; flags the enabled cycle
// that brings the count to LIMIT. LIMIT = 0 disables expiry.
module mips_cpu_wait_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 2);

  logic [CW-1:0] cnt;

  // Count enabled cycles, holding at LIMIT once reached.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current enabled cycle is the LIMIT-th one.
  assign expired = (LIMIT != 0) && en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates the single Avalon-MM master between instruction fetch and
// load/store. One transaction at a time: latch request, run the bus cycle
// through waitrequest stalls (bounded by a timeout), acknowledge for one cycle.
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          DATA_PRIORITY  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy
);

  arb_state_t  state, next_state;
  grant_t      grant, last_grant;
  logic        req_any, pick_data, pick_misaligned;
  logic        in_bus, bus_end, expired;
  logic [31:0] pick_addr, bus_rdata;

  mips_cpu_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_bus),
    .en     (in_bus && avm_waitrequest),
    .expired(expired)
  );

  // Pick the IDLE-cycle winner and decode the end of a bus cycle.
  always_comb begin
    req_any   = i_req | d_req;
    pick_data = 1'b0;
    if (d_req && !i_req) begin
      pick_data = 1'b1;
    end else if (d_req && i_req) begin
      pick_data = DATA_PRIORITY ? 1'b1 : (last_grant == GRANT_INSTR);
    end
    pick_addr       = pick_data ? d_addr : i_addr;
    pick_misaligned = misaligned(pick_addr);
    in_bus          = (state == BUS_INSTR) || (state == BUS_DATA);
    bus_end         = in_bus && (!avm_waitrequest || expired);
    bus_rdata       = (!avm_waitrequest && avm_read) ? avm_readdata : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          if (pick_misaligned)  next_state = RESP;
          else if (pick_data)   next_state = BUS_DATA;
          else                  next_state = BUS_INSTR;
        end
      end
      BUS_INSTR, BUS_DATA: begin
        if (bus_end) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered bus outputs, responses and grant bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      i_ack          <= 1'b0;
      i_rdata        <= '0;
      i_err          <= 1'b0;
      d_ack          <= 1'b0;
      d_rdata        <= '0;
      d_err          <= 1'b0;
      grant          <= GRANT_INSTR;
      last_grant     <= GRANT_INSTR;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            grant <= pick_data ? GRANT_DATA : GRANT_INSTR;
            if (pick_misaligned) begin
              if (pick_data) begin
                d_ack   <= 1'b1;
                d_rdata <= '0;
                d_err   <= 1'b1;
              end else begin
                i_ack   <= 1'b1;
                i_rdata <= '0;
                i_err   <= 1'b1;
              end
            end else begin
              avm_address    <= pick_addr;
              avm_read       <= pick_data ? !d_we : 1'b1;
              avm_write      <= pick_data & d_we;
              avm_writedata  <= pick_data ? d_wdata : '0;
              avm_byteenable <= pick_data ? d_byteenable : BE_WORD;
            end
          end
        end
        BUS_INSTR, BUS_DATA: begin
          if (bus_end) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (grant == GRANT_DATA) begin
              d_ack   <= 1'b1;
              d_rdata <= bus_rdata;
              d_err   <= avm_waitrequest;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= bus_rdata;
              i_err   <= avm_waitrequest;
            end
          end
        end
        RESP: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

  // Busy whenever a transaction is in flight.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: one data-priority instance and one
// alternating instance, driven by directed and random transactions and
// compared against a transaction-level model of the arbitration rules.
module tb_mips_cpu_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset           [2];
  logic        i_req           [2];
  logic [31:0] i_addr          [2];
  logic        i_ack           [2];
  logic [31:0] i_rdata         [2];
  logic        i_err           [2];
  logic        d_req           [2];
  logic        d_we            [2];
  logic [31:0] d_addr          [2];
  logic [31:0] d_wdata         [2];
  logic [3:0]  d_byteenable    [2];
  logic        d_ack           [2];
  logic [31:0] d_rdata         [2];
  logic        d_err           [2];
  logic [31:0] avm_address     [2];
  logic        avm_read        [2];
  logic        avm_write       [2];
  logic [31:0] avm_writedata   [2];
  logic [3:0]  avm_byteenable  [2];
  logic [31:0] avm_readdata    [2];
  logic        avm_waitrequest [2];
  logic        busy            [2];

  int checks = 0;
  int errors = 0;
  bit last_data [2];   // model: 1 when the previous grant went to data

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_cpu_mem_arbiter #(
      .TIMEOUT_CYCLES(TMO),
      .DATA_PRIORITY (g == 0)
    ) u_dut (
      .clk            (clk),
      .reset          (reset[g]),
      .i_req          (i_req[g]),
      .i_addr         (i_addr[g]),
      .i_ack          (i_ack[g]),
      .i_rdata        (i_rdata[g]),
      .i_err          (i_err[g]),
      .d_req          (d_req[g]),
      .d_we           (d_we[g]),
      .d_addr         (d_addr[g]),
      .d_wdata        (d_wdata[g]),
      .d_byteenable   (d_byteenable[g]),
      .d_ack          (d_ack[g]),
      .d_rdata        (d_rdata[g]),
      .d_err          (d_err[g]),
      .avm_address    (avm_address[g]),
      .avm_read       (avm_read[g]),
      .avm_write      (avm_write[g]),
      .avm_writedata  (avm_writedata[g]),
      .avm_byteenable (avm_byteenable[g]),
      .avm_readdata   (avm_readdata[g]),
      .avm_waitrequest(avm_waitrequest[g]),
      .busy           (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to the next cycle, which must be an idle one.
  task automatic idle_check(input int k);
    @(negedge clk);
    chk("idle busy", 32'(busy[k]), 32'd0);
    chk("idle i_ack", 32'(i_ack[k]), 32'd0);
    chk("idle d_ack", 32'(d_ack[k]), 32'd0);
    chk("idle read", 32'(avm_read[k]), 32'd0);
    chk("idle write", 32'(avm_write[k]), 32'd0);
  endtask

  // Serve one granted request whose req was raised in the current cycle 0.
  task automatic serve(input int k, input bit dat, input int waits, input logic [31:0] rd);
    logic [31:0] addr, wd, exp_rd;
    logic [3:0]  be;
    bit          we, misal, hung, strobe, exp_err;
    int          a;
    addr  = dat ? d_addr[k] : i_addr[k];
    we    = dat ? d_we[k] : 1'b0;
    wd    = d_wdata[k];
    be    = dat ? d_byteenable[k] : 4'b1111;
    misal = (addr % 4) != 0;
    hung  = !misal && (waits >= TMO);
    a     = misal ? 1 : (hung ? 1 + TMO : 2 + waits);
    for (int c = 1; c <= a; c++) begin
      @(negedge clk);
      strobe = !misal && (c < a);
      chk("avm_read", 32'(avm_read[k]), 32'(strobe && !we));
      chk("avm_write", 32'(avm_write[k]), 32'(strobe && we));
      if (strobe) begin
        chk("avm_address", avm_address[k], addr);
        chk("avm_byteenable", 32'(avm_byteenable[k]), 32'(be));
        if (we) chk("avm_writedata", avm_writedata[k], wd);
      end
      chk("busy", 32'(busy[k]), 32'd1);
      chk("i_ack", 32'(i_ack[k]), 32'(c == a && !dat));
      chk("d_ack", 32'(d_ack[k]), 32'(c == a && dat));
      if (c == a) begin
        exp_rd  = (misal || hung || we) ? 32'd0 : rd;
        exp_err = misal || hung;
        if (dat) begin
          chk("d_rdata", d_rdata[k], exp_rd);
          chk("d_err", 32'(d_err[k]), 32'(exp_err));
          d_req[k] = 1'b0;
        end else begin
          chk("i_rdata", i_rdata[k], exp_rd);
          chk("i_err", 32'(i_err[k]), 32'(exp_err));
          i_req[k] = 1'b0;
        end
        avm_waitrequest[k] = 1'b0;
        last_data[k] = dat;
      end else if (!misal) begin
        avm_waitrequest[k] = (c - 1) < waits;
        avm_readdata[k]    = ((c - 1) < waits) ? $urandom : rd;
        // the arbiter latched the request; later input changes must not leak
        if (dat) begin
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
        end else begin
          i_addr[k] = $urandom;
        end
      end
    end
  endtask

  task automatic do_txn(input int k, input bit ir, input bit dr,
                        input logic [31:0] ia, input logic [31:0] da, input bit we,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int iw, input int dw,
                        input logic [31:0] ird, input logic [31:0] drd);
    bit first_data;
    idle_check(k);
    i_req[k] = ir;  i_addr[k] = ia;
    d_req[k] = dr;  d_addr[k] = da;  d_we[k] = we;
    d_wdata[k] = wd;  d_byteenable[k] = be;
    first_data = dr && (!ir || (k == 0) || !last_data[k]);
    serve(k, first_data, first_data ? dw : iw, first_data ? drd : ird);
    if (ir && dr) begin
      idle_check(k);
      serve(k, !first_data, first_data ? iw : dw, first_data ? ird : drd);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  function automatic int rnd_waits();
    return ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 3);
  endfunction

  task automatic reset_mid_txn(input int k);
    idle_check(k);
    d_req[k] = 1'b1;  d_we[k] = 1'b0;  d_addr[k] = 32'h40;  d_byteenable[k] = 4'hF;
    @(negedge clk);
    chk("rst pre read", 32'(avm_read[k]), 32'd1);
    avm_waitrequest[k] = 1'b1;
    @(negedge clk);
    chk("rst stalled read", 32'(avm_read[k]), 32'd1);
    reset[k] = 1'b1;
    d_req[k] = 1'b0;
    @(negedge clk);
    chk("rst read", 32'(avm_read[k]), 32'd0);
    chk("rst write", 32'(avm_write[k]), 32'd0);
    chk("rst d_ack", 32'(d_ack[k]), 32'd0);
    chk("rst busy", 32'(busy[k]), 32'd0);
    reset[k] = 1'b0;
    avm_waitrequest[k] = 1'b0;
    last_data[k] = 1'b0;
    @(negedge clk);
    chk("post rst d_ack", 32'(d_ack[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;  i_req[k] = 1'b0;  i_addr[k] = '0;
      d_req[k] = 1'b0;  d_we[k] = 1'b0;  d_addr[k] = '0;  d_wdata[k] = '0;
      d_byteenable[k] = '0;  avm_readdata[k] = '0;  avm_waitrequest[k] = 1'b0;
      last_data[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset i_ack", 32'(i_ack[k]), 32'd0);
      chk("reset d_ack", 32'(d_ack[k]), 32'd0);
      chk("reset i_rdata", i_rdata[k], 32'd0);
      chk("reset d_rdata", d_rdata[k], 32'd0);
      chk("reset i_err", 32'(i_err[k]), 32'd0);
      chk("reset d_err", 32'(d_err[k]), 32'd0);
      chk("reset avm_address", avm_address[k], 32'd0);
      chk("reset avm_read", 32'(avm_read[k]), 32'd0);
      chk("reset avm_write", 32'(avm_write[k]), 32'd0);
      chk("reset avm_be", 32'(avm_byteenable[k]), 32'd0);
      chk("reset busy", 32'(busy[k]), 32'd0);
      reset[k] = 1'b0;
    end

    // data-priority instance: directed cases
    do_txn(0, 1, 0, 32'h10, 32'h0, 0, 32'h0, 4'hF, 0, 0, 32'h8C220004, 32'h0);
    do_txn(0, 0, 1, 32'h0, 32'h20, 1, 32'hDEADBEEF, 4'b0011, 0, 3, 32'h0, 32'h12345678);
    do_txn(0, 1, 1, 32'h200, 32'h100, 0, 32'h0, 4'hF, 0, 1, 32'hAAAA5555, 32'h0BADF00D);
    do_txn(0, 0, 1, 32'h0, 32'h6, 0, 32'h0, 4'hF, 0, 0, 32'h0, 32'h11111111);
    do_txn(0, 1, 0, 32'h30, 32'h0, 0, 32'h0, 4'hF, 100, 0, 32'hFFFFFFFF, 32'h0);
    do_txn(0, 1, 0, 32'h34, 32'h0, 0, 32'h0, 4'hF, TMO - 1, 0, 32'h13579BDF, 32'h0);
    do_txn(0, 1, 0, 32'h35, 32'h0, 0, 32'h0, 4'hF, 0, 0, 32'h2468ACE0, 32'h0);
    reset_mid_txn(0);
    do_txn(0, 0, 1, 32'h0, 32'h44, 0, 32'h0, 4'b1100, 0, 2, 32'h0, 32'hCAFEF00D);

    // alternating instance: last grant instr -> data first; after data -> instr first
    do_txn(1, 1, 1, 32'h300, 32'h400, 0, 32'h0, 4'hF, 0, 0, 32'h01010101, 32'h02020202);
    do_txn(1, 0, 1, 32'h0, 32'h404, 1, 32'h55AA55AA, 4'hF, 0, 1, 32'h0, 32'h0);
    do_txn(1, 1, 1, 32'h304, 32'h408, 0, 32'h0, 4'hF, 2, 0, 32'h03030303, 32'h04040404);

    // random traffic on both instances
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++) begin
        bit ir, dr;
        ir = 1'($urandom_range(0, 1));
        dr = ir ? 1'($urandom_range(0, 1)) : 1'b1;
        do_txn(k, ir, dr, rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)), $urandom,
               4'($urandom_range(1, 15)), rnd_waits(), rnd_waits(), $urandom, $urandom);
      end
    end

    idle_check(0);
    idle_check(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
